// File: rtl/dte_diag_sequencer_pkg.sv
// Shared types for the multi-channel EBUS diagnostic sequencer.
package dte_diag_sequencer_pkg;

  typedef enum logic [1:0] {
    DTE_DIAG_FUNC  = 2'd0,
    DTE_DIAG_READ  = 2'd1,
    DTE_DIAG_WRITE = 2'd2
  } fe_req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_POST
  } seq_state_e;

  // Encoding 3 is undefined on the front-end and behaves as a plain function.
  function automatic fe_req_type_e norm_type(input logic [1:0] t);
    case (t)
      2'd1:    return DTE_DIAG_READ;
      2'd2:    return DTE_DIAG_WRITE;
      default: return DTE_DIAG_FUNC;
    endcase
  endfunction

endpackage

// File: rtl/dte_diag_sequencer_if.sv
// Front-end request/reply bundle between the DPI shim and the sequencer.
interface dte_diag_sequencer_if #(
  parameter int NCHAN = 2,
  parameter int DW    = 36,
  parameter int DSW   = 7,
  localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
);
  logic [NCHAN-1:0]          req_valid;
  logic [NCHAN-1:0]          req_ready;
  logic [NCHAN-1:0][1:0]     req_type;
  logic [NCHAN-1:0][DSW-1:0] req_ds;
  logic [NCHAN-1:0][DW-1:0]  req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [CW-1:0]             rsp_chan;
  logic [1:0]                rsp_type;
  logic [DSW-1:0]            rsp_ds;
  logic [DW-1:0]             rsp_data;

  modport master (
    output req_valid, req_type, req_ds, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_chan, rsp_type, rsp_ds, rsp_data
  );

  modport slave (
    input  req_valid, req_type, req_ds, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_chan, rsp_type, rsp_ds, rsp_data
  );
endinterface

// File: rtl/dte_diag_sequencer_reply_fifo.sv
// First-word-fall-through reply queue; power-of-two depth, pointers wrap naturally.
module dte_diag_sequencer_reply_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FULL) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;
endmodule

// File: rtl/dte_diag_sequencer.sv
// Round-robin front-end arbiter driving one EBUS diag transaction at a time,
// with phase timing for ds/strobe/driver and a reply FIFO toward the shim.
module dte_diag_sequencer
  import dte_diag_sequencer_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int RQ_DEPTH   = 4,
  parameter int DW         = 36,
  parameter int DSW        = 7,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 CROBAR,
  dte_diag_sequencer_if.slave  fe,
  output logic [DSW-1:0]       ebus_ds,
  output logic                 ebus_diag_strobe,
  output logic                 ebus_drive,
  output logic [DW-1:0]        ebus_dout,
  input  logic [DW-1:0]        ebus_din
);
  localparam int CW      = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int FAW     = $clog2(RQ_DEPTH);
  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [FAW:0] FIFO_FULL = (FAW+1)'(RQ_DEPTH);

  typedef struct packed {
    logic [CW-1:0]  chan;
    fe_req_type_e   rtype;
    logic [DSW-1:0] ds;
    logic [DW-1:0]  data;
  } reply_t;

  seq_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   rr_q, rr_d;
  reply_t          cur_q, cur_d;
  logic [DSW-1:0]  ds_q, ds_d;
  logic            strobe_q, strobe_d;
  logic            drive_q, drive_d;
  logic [DW-1:0]   dout_q, dout_d;

  logic            grant_any;
  logic [CW-1:0]   grant_idx;
  logic            accept;
  fe_req_type_e    g_type;
  logic            push;
  reply_t          push_rep, head;
  logic            head_vld;
  logic [FAW:0]    fifo_cnt;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCHAN; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NCHAN) j = j - NCHAN;
      if (!grant_any && fe.req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = CW'(j);
      end
    end
  end

  // Only start when the reply is guaranteed a slot; nothing is in flight while IDLE.
  assign accept       = (state_q == ST_IDLE) && CROBAR && (fifo_cnt != FIFO_FULL) && grant_any;
  assign fe.req_ready = accept ? (NCHAN'(1) << grant_idx) : '0;
  assign g_type       = norm_type(fe.req_type[grant_idx]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    ds_d     = ds_q;
    strobe_d = 1'b0;
    drive_d  = drive_q;
    dout_d   = dout_q;
    push     = 1'b0;
    push_rep = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SETUP;
          cnt_d       = '0;
          rr_d        = (grant_idx == CW'(NCHAN - 1)) ? '0 : grant_idx + CW'(1);
          cur_d.chan  = grant_idx;
          cur_d.rtype = g_type;
          cur_d.ds    = fe.req_ds[grant_idx];
          cur_d.data  = '0;
          ds_d        = fe.req_ds[grant_idx];
          drive_d     = (g_type == DTE_DIAG_WRITE);
          dout_d      = (g_type == DTE_DIAG_WRITE) ? fe.req_data[grant_idx] : '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNTW'(SETUP_CYC - 1)) begin
          state_d  = ST_STROBE;
          cnt_d    = '0;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNTW'(STROBE_CYC - 1)) begin
          state_d = ST_POST;
          drive_d = 1'b0;
          dout_d  = '0;
          // Capture the bus on the final strobe cycle, while the target still drives it.
          if (cur_q.rtype == DTE_DIAG_READ) cur_d.data = ebus_din;
        end else begin
          cnt_d    = cnt_q + CNTW'(1);
          strobe_d = 1'b1;
        end
      end
      ST_POST: begin
        push          = 1'b1;
        push_rep.data = (cur_q.rtype == DTE_DIAG_READ) ? cur_q.data : '0;
        state_d       = ST_IDLE;
        ds_d          = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CROBAR) begin
    if (!CROBAR) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      cur_q    <= '0;
      ds_q     <= '0;
      strobe_q <= 1'b0;
      drive_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      cur_q    <= cur_d;
      ds_q     <= ds_d;
      strobe_q <= strobe_d;
      drive_q  <= drive_d;
      dout_q   <= dout_d;
    end
  end

  dte_diag_sequencer_reply_fifo #(
    .DEPTH (RQ_DEPTH),
    .W     ($bits(reply_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (CROBAR),
    .push  (push),
    .din   (push_rep),
    .pop   (fe.rsp_ready),
    .dout  (head),
    .valid (head_vld),
    .count (fifo_cnt)
  );

  assign fe.rsp_valid = head_vld;
  assign fe.rsp_chan  = head_vld ? head.chan  : '0;
  assign fe.rsp_type  = head_vld ? head.rtype : 2'd0;
  assign fe.rsp_ds    = head_vld ? head.ds    : '0;
  assign fe.rsp_data  = head_vld ? head.data  : '0;

  assign ebus_ds          = ds_q;
  assign ebus_diag_strobe = strobe_q;
  assign ebus_drive       = drive_q;
  assign ebus_dout        = dout_q;
endmodule

// File: tb/tb_dte_diag_sequencer.sv
// Bench for dte_diag_sequencer: directed vector table, corner sequences and a
// randomized run against a transaction-level model.
module tb_dte_diag_sequencer;
  localparam int NCHAN = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 36;
  localparam int DSW   = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DSW-1:0] ebus_ds;
  logic ebus_diag_strobe, ebus_drive;
  logic [DW-1:0] ebus_dout, ebus_din;

  always #5 clk = ~clk;

  dte_diag_sequencer_if #(.NCHAN(NCHAN), .DW(DW), .DSW(DSW)) fe ();

  dte_diag_sequencer #(
    .NCHAN(NCHAN), .RQ_DEPTH(DEPTH), .DW(DW), .DSW(DSW), .SETUP_CYC(1), .STROBE_CYC(2)
  ) dut (
    .clk(clk), .CROBAR(rst_n), .fe(fe),
    .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe), .ebus_drive(ebus_drive),
    .ebus_dout(ebus_dout), .ebus_din(ebus_din)
  );

  int nchk = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fe.req_valid = '0;
    fe.req_type  = '0;
    fe.req_ds    = '0;
    fe.req_data  = '0;
    fe.rsp_ready = 1'b0;
    ebus_din     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    int          ch;
    logic [1:0]  ty;
    logic [6:0]  ds;
    logic [35:0] wd;
    logic [35:0] din;
    logic [1:0]  ety;
    logic [35:0] edata;
    logic        edrv;
  } vec_t;

  typedef struct {
    int          ch;
    logic [1:0]  ty;
    logic [6:0]  ds;
    logic [35:0] data;
  } rep_t;

  vec_t tbl[4];
  logic [6:0] tagq[$];
  logic [6:0] tmp;
  int w, n, acc, last, tag, got, g, ph, thr;
  bit inflight;
  int acc_k, rr;
  bit has[NCHAN];
  logic [1:0] rty[NCHAN];
  logic [6:0] rds[NCHAN];
  logic [35:0] rwd[NCHAN];
  rep_t expq[$];
  rep_t inf;
  logic [35:0] inf_wd;
  bit inf_wr;

  initial begin
    tbl[0] = '{0, 2'd1, 7'h2A, 36'h0,         36'o123456701234, 2'd1, 36'o123456701234, 1'b0};
    tbl[1] = '{1, 2'd2, 7'h11, 36'hF0F0F0F0F, 36'hFFFFFFFFF,    2'd2, 36'h0,            1'b1};
    tbl[2] = '{0, 2'd0, 7'h7F, 36'h123,       36'hABCDE,        2'd0, 36'h0,            1'b0};
    tbl[3] = '{1, 2'd3, 7'h05, 36'h555,       36'h777,          2'd0, 36'h0,            1'b0};

    // Reset state, with requests already pending.
    clear_inputs();
    fe.req_valid = 2'b11;
    #23;
    chk("rst req_ready", fe.req_ready, 0);
    chk("rst strobe", ebus_diag_strobe, 0);
    chk("rst drive", ebus_drive, 0);
    chk("rst ds", ebus_ds, 0);
    chk("rst rsp_valid", fe.rsp_valid, 0);
    do_reset();

    // Single-transaction vector table.
    for (int v = 0; v < 4; v++) begin
      fe.req_valid[tbl[v].ch] = 1'b1;
      fe.req_type[tbl[v].ch]  = tbl[v].ty;
      fe.req_ds[tbl[v].ch]    = tbl[v].ds;
      fe.req_data[tbl[v].ch]  = tbl[v].wd;
      ebus_din = tbl[v].din;
      #1;
      chk("vec ready", fe.req_ready, 64'd1 << tbl[v].ch);
      step();
      fe.req_valid = '0;
      chk("vec setup strobe", ebus_diag_strobe, 0);
      chk("vec setup ds", ebus_ds, tbl[v].ds);
      chk("vec setup drive", ebus_drive, tbl[v].edrv);
      chk("vec setup dout", ebus_dout, tbl[v].edrv ? tbl[v].wd : 36'h0);
      for (int s = 0; s < 2; s++) begin
        step();
        chk("vec strobe", ebus_diag_strobe, 1);
        chk("vec strobe ds", ebus_ds, tbl[v].ds);
        chk("vec strobe drive", ebus_drive, tbl[v].edrv);
        chk("vec strobe dout", ebus_dout, tbl[v].edrv ? tbl[v].wd : 36'h0);
      end
      step();
      chk("vec post strobe", ebus_diag_strobe, 0);
      chk("vec post drive", ebus_drive, 0);
      chk("vec post dout", ebus_dout, 0);
      chk("vec post ds", ebus_ds, tbl[v].ds);
      chk("vec post rsp_valid", fe.rsp_valid, 0);
      step();
      chk("vec rsp_valid", fe.rsp_valid, 1);
      chk("vec rsp_chan", fe.rsp_chan, tbl[v].ch);
      chk("vec rsp_type", fe.rsp_type, tbl[v].ety);
      chk("vec rsp_ds", fe.rsp_ds, tbl[v].ds);
      chk("vec rsp_data", fe.rsp_data, tbl[v].edata);
      fe.rsp_ready = 1'b1;
      step();
      fe.rsp_ready = 1'b0;
      chk("vec popped", fe.rsp_valid, 0);
    end

    // Both channels saturated: alternating grants, fixed spacing.
    do_reset();
    fe.rsp_ready = 1'b1;
    fe.req_valid = 2'b11;
    n = 0;
    last = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      if (fe.req_ready != '0) begin
        w = fe.req_ready[1] ? 1 : 0;
        chk("rr grant", w, n % 2);
        if (n > 0) chk("issue spacing", i - last, 5);
        last = i;
        n++;
      end
      step();
    end
    chk("rr grant count", n, 4);

    // Reply backpressure: FIFO fills, then one pop admits exactly one more.
    do_reset();
    tagq.delete();
    tag = 1;
    fe.req_ds[0] = 7'(tag); tag++;
    fe.req_ds[1] = 7'(tag); tag++;
    fe.req_valid = 2'b11;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (fe.req_ready != '0) begin
        w = fe.req_ready[1] ? 1 : 0;
        tagq.push_back(fe.req_ds[w]);
        acc++;
        step();
        fe.req_ds[w] = 7'(tag); tag++;
      end else step();
    end
    chk("fill accepts", acc, 4);
    chk("full ready", fe.req_ready, 0);
    chk("full rsp_valid", fe.rsp_valid, 1);
    chk("full head", fe.rsp_ds, tagq[0]);
    fe.rsp_ready = 1'b1;
    step();
    fe.rsp_ready = 1'b0;
    tmp = tagq.pop_front();
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (fe.req_ready != '0) begin
        w = fe.req_ready[1] ? 1 : 0;
        tagq.push_back(fe.req_ds[w]);
        acc++;
      end
      step();
    end
    chk("refill accepts", acc, 1);
    fe.req_valid = '0;

    // Push and pop on the same edge with three entries queued.
    fe.rsp_ready = 1'b1;
    step();
    fe.rsp_ready = 1'b0;
    tmp = tagq.pop_front();
    fe.req_ds[0] = 7'h70;
    fe.req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      #1;
      if (fe.req_ready[0]) begin
        got = 1;
        tagq.push_back(fe.req_ds[0]);
      end
      step();
    end
    chk("pp accept", got, 1);
    fe.req_valid = '0;
    repeat (3) step();
    chk("pp head", fe.rsp_ds, tagq[0]);
    fe.rsp_ready = 1'b1;
    step();
    tmp = tagq.pop_front();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (fe.rsp_valid) begin
        if (tagq.size() > 0) begin
          tmp = tagq.pop_front();
          chk("pp order", fe.rsp_ds, tmp);
        end
        n++;
      end
      step();
    end
    chk("pp count", n, 3);
    chk("pp drained", tagq.size(), 0);

    // Reset asserted in the middle of the strobe phase.
    do_reset();
    fe.req_valid = 2'b01;
    fe.req_type[0] = 2'd2;
    fe.req_ds[0] = 7'h33;
    fe.req_data[0] = 36'hABCDE1234;
    #1;
    chk("abort ready", fe.req_ready, 1);
    step();
    fe.req_valid = '0;
    step();
    chk("abort in strobe", ebus_diag_strobe, 1);
    chk("abort driving", ebus_drive, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort strobe", ebus_diag_strobe, 0);
    chk("abort drive", ebus_drive, 0);
    chk("abort ds", ebus_ds, 0);
    chk("abort dout", ebus_dout, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("abort no reply", fe.rsp_valid, 0);
    fe.req_valid = 2'b11;
    #1;
    chk("abort rr", fe.req_ready, 1);
    fe.req_valid = '0;

    // Randomized traffic against the transaction-level model.
    do_reset();
    inflight = 0;
    acc_k = 0;
    rr = 0;
    expq.delete();
    for (int c = 0; c < NCHAN; c++) has[c] = 0;
    for (int k = 0; k < 800; k++) begin
      if (inflight && k == acc_k + 5) begin
        expq.push_back(inf);
        inflight = 0;
      end
      chk("rnd rsp_valid", fe.rsp_valid, expq.size() > 0);
      if (expq.size() > 0) begin
        chk("rnd rsp_chan", fe.rsp_chan, expq[0].ch);
        chk("rnd rsp_type", fe.rsp_type, expq[0].ty);
        chk("rnd rsp_ds", fe.rsp_ds, expq[0].ds);
        chk("rnd rsp_data", fe.rsp_data, expq[0].data);
      end
      ph = inflight ? k - acc_k : 0;
      chk("rnd strobe", ebus_diag_strobe, inflight && (ph == 2 || ph == 3));
      chk("rnd drive", ebus_drive, inflight && inf_wr && ph <= 3);
      chk("rnd dout", ebus_dout, (inflight && inf_wr && ph <= 3) ? inf_wd : 36'h0);
      if (inflight) chk("rnd ds", ebus_ds, inf.ds);

      ebus_din = {4'($urandom), 32'($urandom)};
      if (inflight && k == acc_k + 3 && inf.ty == 2'd1) inf.data = ebus_din;
      for (int c = 0; c < NCHAN; c++) begin
        if (!has[c] && $urandom_range(2, 0) != 0) begin
          has[c] = 1;
          rty[c] = 2'($urandom_range(3, 0));
          rds[c] = 7'($urandom);
          rwd[c] = {4'($urandom), 32'($urandom)};
        end
        fe.req_valid[c] = has[c];
        fe.req_type[c]  = rty[c];
        fe.req_ds[c]    = rds[c];
        fe.req_data[c]  = rwd[c];
      end
      thr = ((k / 200) % 2 == 1) ? 85 : 15;
      fe.rsp_ready = ($urandom_range(99, 0) < thr);
      #1;
      g = -1;
      if (!inflight && expq.size() < DEPTH)
        for (int j = 0; j < NCHAN; j++)
          if (g < 0 && has[(rr + j) % NCHAN]) g = (rr + j) % NCHAN;
      chk("rnd req_ready", fe.req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
      if (g >= 0) begin
        inflight = 1;
        acc_k = k;
        rr = (g + 1) % NCHAN;
        inf.ch = g;
        inf.ty = (rty[g] == 2'd3) ? 2'd0 : rty[g];
        inf.ds = rds[g];
        inf.data = '0;
        inf_wr = (rty[g] == 2'd2);
        inf_wd = rwd[g];
        has[g] = 0;
      end
      if (expq.size() > 0 && fe.rsp_ready) expq.pop_front();
      step();
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
